// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU datapath types for the writeback arbiter slice.
// Provides the word and register-select types and the register mask type.
// Also provides a helper that turns a register number into a scoreboard mask.
package regfile_wb_arbiter_pkg;

    localparam int WORD_W  = 32;
    localparam int REGBITS = 5;
    localparam int REGS    = 32;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [REGBITS-1:0] regbits_t;
    typedef logic [REGS-1:0]    regmask_t;

    // One-hot mask for a register; r0 never appears because it is hardwired zero.
    function automatic regmask_t reg_mask(input regbits_t sel);
        regmask_t m;
        m      = '0;
        m[sel] = 1'b1;
        m[0]   = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps modulo N; the first asserted request wins.
// The caller owns the rotating pointer register.
module regfile_wb_arbiter_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand_s;
    logic          found_s;

    // Rotating-priority search: walk N candidates starting at ptr and grant the first live one
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IW'((int'(ptr) + k) % N);
            if (!found_s && req[cand_s]) begin
                found_s      = 1'b1;
                gnt[cand_s]  = 1'b1;
                gnt_idx      = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file's single write port.
// Round-robin arbitration among N_REQ writeback sources, a registered write,
// a 32-entry pending-write scoreboard and read-hazard flags.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int N_REQ = 3
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*5-1:0]  req_wsel,
    input  logic [N_REQ*32-1:0] req_wdat,
    output logic [N_REQ-1:0]    gnt,
    output logic                rf_WEN,
    output logic [4:0]          rf_wsel,
    output logic [31:0]         rf_wdat,
    input  logic                issue_en,
    input  logic [4:0]          issue_sel,
    input  logic                flush,
    input  logic [4:0]          rsel1,
    input  logic [4:0]          rsel2,
    output logic                hazard1,
    output logic                hazard2,
    output logic [31:0]         busy
);

    localparam int PW = $clog2(N_REQ);

    logic [N_REQ-1:0] req_live_s;
    logic [N_REQ-1:0] gnt_s;
    logic [PW-1:0]    gnt_idx_s;
    logic             any_gnt_s;
    logic [PW-1:0]    ptr_r;
    logic [PW-1:0]    ptr_nxt_s;
    regbits_t         sel_wsel_s;
    word_t            sel_wdat_s;
    logic             rf_wen_r;
    regbits_t         rf_wsel_r;
    word_t            rf_wdat_r;
    regmask_t         busy_r;
    regmask_t         busy_nxt_s;

    // No requester can be granted while reset is held, so mask requests with nRST
    assign req_live_s = nRST ? req : {N_REQ{1'b0}};

    regfile_wb_arbiter_rr_arbiter #(
        .N  (N_REQ),
        .IW (PW)
    ) u_arb (
        .req     (req_live_s),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    assign gnt       = gnt_s;
    assign any_gnt_s = |gnt_s;

    // Pointer moves just past the winner so it becomes lowest priority next time
    always_comb begin
        ptr_nxt_s = ptr_r;
        if (any_gnt_s) begin
            if (gnt_idx_s == PW'(N_REQ - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = gnt_idx_s + PW'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    // Select the granted requester's destination and data
    always_comb begin
        sel_wsel_s = '0;
        sel_wdat_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_wsel_s = req_wsel[i*5 +: 5];
                sel_wdat_s = req_wdat[i*32 +: 32];
            end else begin
                sel_wsel_s = sel_wsel_s;
            end
        end
    end

    // Registered write port; a granted write to r0 completes the handshake but never enables the write
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rf_wen_r  <= 1'b0;
            rf_wsel_r <= 5'd0;
            rf_wdat_r <= 32'd0;
        end else if (any_gnt_s) begin
            rf_wen_r  <= (sel_wsel_s != 5'd0);
            rf_wsel_r <= sel_wsel_s;
            rf_wdat_r <= sel_wdat_s;
        end else begin
            rf_wen_r  <= 1'b0;
        end
    end

    assign rf_WEN  = rf_wen_r;
    assign rf_wsel = rf_wsel_r;
    assign rf_wdat = rf_wdat_r;

    // Scoreboard next state: commit clears, flush wipes, and a new issue always wins last
    always_comb begin
        busy_nxt_s = busy_r;
        if (rf_wen_r) begin
            busy_nxt_s = busy_nxt_s & ~reg_mask(rf_wsel_r);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (flush) begin
            busy_nxt_s = '0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (issue_en) begin
            busy_nxt_s = busy_nxt_s | reg_mask(issue_sel);
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Pending-write scoreboard register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

    // The bit stays set through the commit edge, so a registered read on that
    // same edge still reports a hazard and sees the stale value flagged
    assign hazard1 = (rsel1 != 5'd0) && busy_r[rsel1];
    assign hazard2 = (rsel2 != 5'd0) && busy_r[rsel2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Requesters, pointer and scoreboard are modelled with plain arrays and integers;
// expected register-file writes go into a queue checked by an independent monitor.
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic            CLK = 1'b0;
    logic            nRST;
    logic [N-1:0]    req;
    logic [N*5-1:0]  req_wsel;
    logic [N*32-1:0] req_wdat;
    logic [N-1:0]    gnt;
    logic            rf_WEN;
    logic [4:0]      rf_wsel;
    logic [31:0]     rf_wdat;
    logic            issue_en;
    logic [4:0]      issue_sel;
    logic            flush;
    logic [4:0]      rsel1;
    logic [4:0]      rsel2;
    logic            hazard1;
    logic            hazard2;
    logic [31:0]     busy;

    regfile_wb_arbiter #(.N_REQ(N)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (req),
        .req_wsel  (req_wsel),
        .req_wdat  (req_wdat),
        .gnt       (gnt),
        .rf_WEN    (rf_WEN),
        .rf_wsel   (rf_wsel),
        .rf_wdat   (rf_wdat),
        .issue_en  (issue_en),
        .issue_sel (issue_sel),
        .flush     (flush),
        .rsel1     (rsel1),
        .rsel2     (rsel2),
        .hazard1   (hazard1),
        .hazard2   (hazard2),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // reference model state
    bit          pend [N];
    logic [4:0]  pw   [N];
    logic [31:0] pd   [N];
    int          ptr_m   = 0;
    logic [31:0] busy_m  = 32'd0;
    bit          wen_m   = 1'b0;
    logic [4:0]  wsel_m  = 5'd0;
    logic [36:0] wq [$];
    logic [36:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every committed write must match the oldest expected write
    always @(negedge CLK) begin
        if (nRST === 1'b1 && rf_WEN === 1'b1) begin
            tests++;
            if (wq.size() == 0) begin
                fails++;
                $display("FAIL wb_unexpected: got wsel=%0d wdat=%h expected no write", rf_wsel, rf_wdat);
            end else begin
                mon_exp = wq.pop_front();
                if ({rf_wsel, rf_wdat} !== mon_exp) begin
                    fails++;
                    $display("FAIL wb_data: got wsel=%0d wdat=%h expected wsel=%0d wdat=%h",
                             rf_wsel, rf_wdat, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic arm(input int i, input logic [4:0] sel, input logic [31:0] dat);
        pend[i] = 1'b1;
        pw[i]   = sel;
        pd[i]   = dat;
    endtask

    // one clock cycle: drive, check combinational outputs and state, advance model
    task automatic step(input bit ie, input logic [4:0] is, input bit fl,
                        input logic [4:0] r1, input logic [4:0] r2);
        int g;
        int idx;
        logic [N-1:0] exp_gnt;
        @(negedge CLK);
        for (int i = 0; i < N; i++) begin
            req[i]            = pend[i];
            req_wsel[i*5 +: 5]  = pw[i];
            req_wdat[i*32 +: 32] = pd[i];
        end
        issue_en = ie; issue_sel = is; flush = fl; rsel1 = r1; rsel2 = r2;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (g < 0 && pend[idx]) g = idx;
        end
        exp_gnt = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("busy", busy, busy_m);
        chk("rf_WEN", 32'(rf_WEN), 32'(wen_m));
        chk("hazard1", 32'(hazard1), 32'((r1 != 5'd0) && busy_m[r1]));
        chk("hazard2", 32'(hazard2), 32'((r2 != 5'd0) && busy_m[r2]));
        if (wen_m) busy_m[wsel_m] = 1'b0;
        if (fl) busy_m = 32'd0;
        if (ie && is != 5'd0) busy_m[is] = 1'b1;
        if (g >= 0) begin
            wen_m  = (pw[g] != 5'd0);
            wsel_m = pw[g];
            if (wen_m) wq.push_back({pw[g], pd[g]});
            pend[g] = 1'b0;
            ptr_m   = (g + 1) % N;
        end else begin
            wen_m = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    endtask

    // asynchronous reset pulse in the middle of a cycle
    task automatic pulse_reset();
        @(negedge CLK);
        #2;
        req = '0; issue_en = 1'b0; flush = 1'b0;
        nRST = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wen", 32'(rf_WEN), 32'd0);
        chk("rst_wsel", 32'(rf_wsel), 32'd0);
        chk("rst_wdat", rf_wdat, 32'd0);
        chk("rst_busy", busy, 32'd0);
        ptr_m = 0; busy_m = 32'd0; wen_m = 1'b0; wsel_m = 5'd0;
        @(negedge CLK);
        #2;
        nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        req = 3'b111; req_wsel = '0; req_wdat = '0;
        issue_en = 1'b0; issue_sel = 5'd0; flush = 1'b0; rsel1 = 5'd0; rsel2 = 5'd0;
        for (int i = 0; i < N; i++) arm(i, 5'(i + 1), 32'h1000 + 32'(i));

        // 1: reset state with all requesting, then fair rotation
        #13;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wen", 32'(rf_WEN), 32'd0);
        chk("rst_busy", busy, 32'd0);
        req = '0;
        @(negedge CLK);
        #2;
        nRST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
            for (int i = 0; i < N; i++) if (!pend[i]) arm(i, 5'(i + 1), 32'h2000 + 32'(c));
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(2);

        // 2: single requester, one-cycle write latency
        arm(1, 5'd5, 32'hDEADBEEF);
        idle(3);

        // 3: issue sets busy/hazard, commit clears it one edge after rf_WEN
        step(1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        step(1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
        arm(0, 5'd7, 32'h0000_0777);
        step(1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        step(1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        step(1'b0, 5'd0, 1'b0, 5'd7, 5'd0);

        // 4: re-issue on the commit edge keeps the bit
        step(1'b1, 5'd7, 1'b0, 5'd0, 5'd0);
        arm(2, 5'd7, 32'hA5A5_0007);
        step(1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        step(1'b1, 5'd7, 1'b0, 5'd7, 5'd0);
        step(1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        arm(0, 5'd7, 32'h0000_7777);
        idle(3);

        // 5: r0 never goes busy and never writes
        step(1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        arm(0, 5'd0, 32'hFFFF_FFFF);
        idle(3);

        // 6: flush with same-cycle issue, in-flight write survives
        step(1'b1, 5'd4, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd5, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd6, 1'b0, 5'd0, 5'd0);
        step(1'b1, 5'd7, 1'b0, 5'd4, 5'd6);
        arm(1, 5'd9, 32'h0BAD_F00D);
        step(1'b0, 5'd0, 1'b0, 5'd5, 5'd7);
        step(1'b1, 5'd3, 1'b1, 5'd4, 5'd0);
        step(1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
        chk("flush_busy", busy, 32'h0000_0008);

        // asynchronous reset while a write is in flight
        arm(0, 5'd12, 32'h1234_5678);
        arm(2, 5'd13, 32'h8765_4321);
        step(1'b1, 5'd12, 1'b0, 5'd0, 5'd0);
        pulse_reset();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        idle(2);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    arm(i, 5'($urandom_range(0, 31)), $urandom);
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        idle(5);
        @(negedge CLK);
        #2;
        chk("wq_drained", 32'(wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
